// File: rtl/hamming_tx_scheduler_if.sv
// Byte-serializer handshake shared between the scheduler (master) and the
// UART TX serializer (slave).
interface hamming_tx_scheduler_if;
    logic       tx_start;  // one-cycle start pulse
    logic [7:0] tx_byte;   // stable from tx_start until tx_done
    logic       tx_busy;   // serializer still shifting a byte
    logic       tx_done;   // one-cycle completion pulse

    modport master (
        output tx_start,
        output tx_byte,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_byte,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/hamming_tx_scheduler.sv
// Round-robin scheduler sharing one UART byte serializer between two nibble
// requesters. The granted nibble is Hamming(8,4) encoded, XORed with that
// requester's error-injection bias and handed to the serializer. Each frame
// is followed by an inter-frame gap; a serializer that never completes is
// abandoned after TIMEOUT_CYCLES with a one-cycle err pulse.
module hamming_tx_scheduler #(
    parameter int unsigned GAP_CYCLES     = 868,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          req0_i,
    input  logic [3:0]                    data0_i,
    input  logic [7:0]                    bias0_i,
    output logic                          ack0_o,

    input  logic                          req1_i,
    input  logic [3:0]                    data1_i,
    input  logic [7:0]                    bias1_i,
    output logic                          ack1_o,

    hamming_tx_scheduler_if.master        tx,

    output logic                          grant_id_o,
    output logic                          busy_o,
    output logic [7:0]                    cnt0_o,
    output logic [7:0]                    cnt1_o,
    output logic                          err_o
);

    // One timer serves both the WAIT_DONE timeout and the GAP count, so it is
    // sized for the larger of the two terminal values.
    localparam int unsigned MaxCnt = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned TimerW = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

    // GAP_CYCLES = 0 still spends one cycle in GAP, same as GAP_CYCLES = 1.
    localparam logic [TimerW-1:0] GapLast =
        (GAP_CYCLES == 0) ? TimerW'(0) : TimerW'(GAP_CYCLES - 1);
    localparam logic [TimerW-1:0] TimeoutLast =
        (TIMEOUT_CYCLES == 0) ? TimerW'(0) : TimerW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitDone,
        StGap
    } state_e;

    state_e              state_q;
    logic [TimerW-1:0]   timer_q;
    logic                last_grant_q;
    logic                grant_id_q;
    logic                ack0_q;
    logic                ack1_q;
    logic                tx_start_q;
    logic [7:0]          tx_byte_q;
    logic [7:0]          cnt0_q;
    logic [7:0]          cnt1_q;
    logic                err_q;

    logic                sel_valid;
    logic                sel_id;
    logic [3:0]          sel_nibble;
    logic [7:0]          sel_bias;
    logic [7:0]          enc_byte;

    // Hamming(8,4): code = {p8,d3,d2,d1,p4,d0,p2,p1}, p8 is overall parity.
    function automatic logic [7:0] hamming_encode(input logic [3:0] d);
        logic p1;
        logic p2;
        logic p4;
        logic p8;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        p8 = p1 ^ p2 ^ p4 ^ d[0] ^ d[1] ^ d[2] ^ d[3];
        return {p8, d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // Arbitration and encoding of the candidate grant.
    always_comb begin
        sel_valid = req0_i | req1_i;
        // With both requesting, the one not served last wins; otherwise the
        // sole requester wins (req1_i alone selects 1, req0_i alone selects 0).
        if (req0_i && req1_i) begin
            sel_id = ~last_grant_q;
        end else begin
            sel_id = req1_i;
        end
        sel_nibble = sel_id ? data1_i : data0_i;
        sel_bias   = sel_id ? bias1_i : bias0_i;
        enc_byte   = hamming_encode(sel_nibble) ^ sel_bias;
    end

    // Scheduler FSM with registered handshake, data and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_byte_q    <= 8'h00;
            cnt0_q       <= 8'h00;
            cnt1_q       <= 8'h00;
            err_q        <= 1'b0;
        end else begin
            // Pulse outputs default low; states below raise them for one cycle.
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (!tx.tx_busy && sel_valid) begin
                        ack0_q       <= ~sel_id;
                        ack1_q       <= sel_id;
                        tx_byte_q    <= enc_byte;
                        grant_id_q   <= sel_id;
                        last_grant_q <= sel_id;
                        state_q      <= StIssue;
                    end
                end

                StIssue: begin
                    tx_start_q <= 1'b1;
                    timer_q    <= '0;
                    state_q    <= StWaitDone;
                end

                StWaitDone: begin
                    // Completion wins over a timeout expiring in the same cycle.
                    if (tx.tx_done) begin
                        if (grant_id_q) begin
                            cnt1_q <= cnt1_q + 8'd1;
                        end else begin
                            cnt0_q <= cnt0_q + 8'd1;
                        end
                        timer_q <= '0;
                        state_q <= StGap;
                    end else if (timer_q == TimeoutLast) begin
                        err_q   <= 1'b1;
                        timer_q <= '0;
                        state_q <= StGap;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end

                StGap: begin
                    if (timer_q == GapLast) begin
                        timer_q <= '0;
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tx.tx_start = tx_start_q;
    assign tx.tx_byte  = tx_byte_q;
    assign ack0_o      = ack0_q;
    assign ack1_o      = ack1_q;
    assign grant_id_o  = grant_id_q;
    assign busy_o      = (state_q != StIdle);
    assign cnt0_o      = cnt0_q;
    assign cnt1_o      = cnt1_q;
    assign err_o       = err_q;

endmodule
